// File: rtl/buf_manager_wbs.sv
// ============================================================================
// Module      : buf_manager_wbs
// Description : Wishbone-slave buffer-id pool. ALLOC/RELEASE of ids through a
//               bitmap, with free count, sticky error status and one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_manager_wbs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BUFS   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_strobe,
  input  logic                  wbs_cycle,
  input  logic                  wbs_write,
  output logic                  wbs_ack,
  output logic [DATA_WIDTH-1:0] free_count,
  output logic                  all_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_BUFS-1:0]   in_use_q, in_use_d;
  logic [2:0]            status_q, status_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
  logic [DATA_WIDTH-1:0] free_count_q, free_count_d;
  logic                  all_busy_q, all_busy_d;

  logic [1:0]            offset;
  logic [NUM_BUFS-1:0]   alloc_mask;
  logic [DATA_WIDTH-1:0] alloc_id;
  logic                  alloc_found;
  logic [NUM_BUFS-1:0]   rel_mask;
  logic                  rel_valid;
  logic                  unused_addr_bits;

  assign offset           = wbs_address[3:2];
  assign unused_addr_bits = ^{wbs_address[ADDR_WIDTH-1:4], wbs_address[1:0]};

  // Scan downward so the last hit written is the lowest free index.
  always_comb begin
    alloc_mask  = '0;
    alloc_id    = '0;
    alloc_found = 1'b0;
    for (int i = NUM_BUFS - 1; i >= 0; i--) begin
      if (!in_use_q[i]) begin
        alloc_mask    = '0;
        alloc_mask[i] = 1'b1;
        alloc_id      = DATA_WIDTH'(i);
        alloc_found   = 1'b1;
      end
    end
  end

  // Full-width compare, so ids beyond the pool never alias onto a valid bit.
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      rel_mask[i] = (wbs_writedata == DATA_WIDTH'(i));
    end
    rel_valid = |rel_mask;
  end

  always_comb begin
    state_d      = state_q;
    in_use_d     = in_use_q;
    status_d     = status_q;
    readdata_d   = readdata_q;
    free_count_d = free_count_q;
    all_busy_d   = all_busy_q;
    case (state_q)
      IDLE: begin
        if (wbs_cycle && wbs_strobe) begin
          state_d = ACK;
          case (offset)
            2'd0: begin
              if (!wbs_write) begin
                if (alloc_found) begin
                  in_use_d     = in_use_q | alloc_mask;
                  readdata_d   = alloc_id;
                  free_count_d = free_count_q - DATA_WIDTH'(1);
                end else begin
                  readdata_d  = '1;
                  status_d[0] = 1'b1;
                end
              end else if (!rel_valid) begin
                status_d[2] = 1'b1;
              end else if ((in_use_q & rel_mask) == '0) begin
                status_d[1] = 1'b1;
              end else begin
                in_use_d     = in_use_q & ~rel_mask;
                free_count_d = free_count_q + DATA_WIDTH'(1);
              end
            end
            2'd1: begin
              if (!wbs_write) readdata_d = free_count_q;
            end
            2'd2: begin
              if (!wbs_write) readdata_d = DATA_WIDTH'(status_q);
              else            status_d   = status_q & ~wbs_writedata[2:0];
            end
            default: begin
              if (!wbs_write) readdata_d = '0;
            end
          endcase
          all_busy_d = (free_count_d == '0);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      in_use_q     <= '0;
      status_q     <= '0;
      readdata_q   <= '0;
      free_count_q <= DATA_WIDTH'(NUM_BUFS);
      all_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_use_q     <= in_use_d;
      status_q     <= status_d;
      readdata_q   <= readdata_d;
      free_count_q <= free_count_d;
      all_busy_q   <= all_busy_d;
    end
  end

  assign wbs_ack      = (state_q == ACK);
  assign wbs_readdata = readdata_q;
  assign free_count   = free_count_q;
  assign all_busy     = all_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_buf_manager_wbs.sv
// ============================================================================
// Module      : tb_buf_manager_wbs
// Description : Directed self-checking bench for buf_manager_wbs (8-id pool).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buf_manager_wbs;

  logic        clk;
  logic        reset_n;
  logic [31:0] wbs_address;
  logic [31:0] wbs_writedata;
  logic [31:0] wbs_readdata;
  logic        wbs_strobe;
  logic        wbs_cycle;
  logic        wbs_write;
  logic        wbs_ack;
  logic [31:0] free_count;
  logic        all_busy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] OFF_POOL   = 32'h0;
  localparam logic [31:0] OFF_COUNT  = 32'h4;
  localparam logic [31:0] OFF_STATUS = 32'h8;
  localparam logic [31:0] OFF_RSVD   = 32'hC;

  buf_manager_wbs #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_BUFS  (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wbs_address  (wbs_address),
    .wbs_writedata(wbs_writedata),
    .wbs_readdata (wbs_readdata),
    .wbs_strobe   (wbs_strobe),
    .wbs_cycle    (wbs_cycle),
    .wbs_write    (wbs_write),
    .wbs_ack      (wbs_ack),
    .free_count   (free_count),
    .all_busy     (all_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transfer: request, bounded wait for ack, drop, confirm ack is single.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd);
    int n;
    @(negedge clk);
    wbs_cycle     = 1'b1;
    wbs_strobe    = 1'b1;
    wbs_write     = we;
    wbs_address   = addr;
    wbs_writedata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs_ack && n < 10);
    check("ack_seen", {31'b0, wbs_ack}, 32'd1);
    rd = wbs_readdata;
    wbs_cycle  = 1'b0;
    wbs_strobe = 1'b0;
    wbs_write  = 1'b0;
    @(negedge clk);
    check("ack_single", {31'b0, wbs_ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] last_rd;
    reset_n       = 1'b1;
    wbs_address   = '0;
    wbs_writedata = '0;
    wbs_strobe    = 1'b0;
    wbs_cycle     = 1'b0;
    wbs_write     = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'b0, wbs_ack}, 32'd0);
    check("rst_readdata", wbs_readdata, 32'd0);
    check("rst_free_count", free_count, 32'd8);
    check("rst_all_busy", {31'b0, all_busy}, 32'd0);
    reset_n = 1'b1;

    // Drain the pool: ids in ascending order.
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, OFF_POOL, 32'd0, rd);
      check($sformatf("alloc_id_%0d", i), rd, 32'(i));
      check($sformatf("alloc_fc_%0d", i), free_count, 32'(7 - i));
    end
    check("all_busy_full", {31'b0, all_busy}, 32'd1);

    xfer(1'b0, OFF_POOL, 32'd0, rd);
    check("alloc_empty_id", rd, 32'hFFFF_FFFF);
    check("alloc_empty_fc", free_count, 32'd0);
    xfer(1'b0, OFF_STATUS, 32'd0, rd);
    check("status_empty", rd, 32'h1);

    xfer(1'b1, OFF_POOL, 32'd5, rd);
    check("rel5_fc", free_count, 32'd1);
    check("rel5_all_busy", {31'b0, all_busy}, 32'd0);
    xfer(1'b0, OFF_COUNT, 32'd0, rd);
    check("count_read", rd, 32'd1);
    xfer(1'b0, OFF_POOL, 32'd0, rd);
    check("realloc_5", rd, 32'd5);
    check("realloc_fc", free_count, 32'd0);
    last_rd = rd;

    xfer(1'b1, OFF_POOL, 32'd3, rd);
    check("rel3_fc", free_count, 32'd1);
    check("write_keeps_rd", wbs_readdata, last_rd);
    xfer(1'b1, OFF_POOL, 32'd3, rd);
    check("rel3_again_fc", free_count, 32'd1);
    xfer(1'b1, OFF_POOL, 32'd9, rd);
    check("rel9_fc", free_count, 32'd1);
    xfer(1'b0, OFF_STATUS, 32'd0, rd);
    check("status_all", rd, 32'h7);
    xfer(1'b1, OFF_STATUS, 32'h6, rd);
    xfer(1'b0, OFF_STATUS, 32'd0, rd);
    check("status_w1c", rd, 32'h1);

    xfer(1'b1, OFF_COUNT, 32'd0, rd);
    check("count_write_ignored", free_count, 32'd1);
    xfer(1'b0, OFF_RSVD, 32'd0, rd);
    check("rsvd_read", rd, 32'd0);

    // Free ids become {0,1,3}; hold strobe over three back-to-back reads.
    xfer(1'b1, OFF_POOL, 32'd0, rd);
    xfer(1'b1, OFF_POOL, 32'd1, rd);
    check("pre_hold_fc", free_count, 32'd3);
    @(negedge clk);
    wbs_cycle   = 1'b1;
    wbs_strobe  = 1'b1;
    wbs_write   = 1'b0;
    wbs_address = OFF_POOL;
    @(negedge clk);
    check("hold_ack0", {31'b0, wbs_ack}, 32'd1);
    check("hold_id0", wbs_readdata, 32'd0);
    @(negedge clk);
    check("hold_gap0", {31'b0, wbs_ack}, 32'd0);
    @(negedge clk);
    check("hold_ack1", {31'b0, wbs_ack}, 32'd1);
    check("hold_id1", wbs_readdata, 32'd1);
    @(negedge clk);
    check("hold_gap1", {31'b0, wbs_ack}, 32'd0);
    @(negedge clk);
    check("hold_ack2", {31'b0, wbs_ack}, 32'd1);
    check("hold_id2", wbs_readdata, 32'd3);
    wbs_cycle  = 1'b0;
    wbs_strobe = 1'b0;
    @(negedge clk);
    check("hold_end_ack", {31'b0, wbs_ack}, 32'd0);
    check("hold_fc", free_count, 32'd0);

    // Reset lands while an ALLOC is being acknowledged.
    xfer(1'b1, OFF_POOL, 32'd2, rd);
    @(negedge clk);
    wbs_cycle   = 1'b1;
    wbs_strobe  = 1'b1;
    wbs_write   = 1'b0;
    wbs_address = OFF_POOL;
    @(negedge clk);
    check("pre_rst_ack", {31'b0, wbs_ack}, 32'd1);
    check("pre_rst_id", wbs_readdata, 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, wbs_ack}, 32'd0);
    check("mid_rst_fc", free_count, 32'd8);
    check("mid_rst_busy", {31'b0, all_busy}, 32'd0);
    check("mid_rst_rd", wbs_readdata, 32'd0);
    wbs_cycle  = 1'b0;
    wbs_strobe = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    xfer(1'b0, OFF_POOL, 32'd0, rd);
    check("post_rst_id", rd, 32'd0);
    check("post_rst_fc", free_count, 32'd7);
    xfer(1'b0, OFF_STATUS, 32'd0, rd);
    check("post_rst_status", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/buf_manager_wbs.md
BUF_MANAGER_WBS -- requirements
Module: buf_manager_wbs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-003 SHALL have parameter NUM_BUFS, default 8, pool size; legal range 2..256.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wbs_address  input  ADDR_WIDTH  register select; only bits [3:2] decoded.
REQ-007 SHALL have port wbs_writedata  input  DATA_WIDTH  write data (buf id or clear mask).
REQ-008 SHALL have port wbs_readdata  output  DATA_WIDTH  registered read data.
REQ-009 SHALL have port wbs_strobe  input  1  transfer request.
REQ-010 SHALL have port wbs_cycle  input  1  bus cycle valid.
REQ-011 SHALL have port wbs_write  input  1  1=write, 0=read.
REQ-012 SHALL have port wbs_ack  output  1  single-cycle transfer acknowledge.
REQ-013 SHALL have port free_count  output  DATA_WIDTH  number of unallocated buffers.
REQ-014 SHALL have port all_busy  output  1  high when free_count == 0.

Function
REQ-015 SHALL keep an NUM_BUFS-bit in_use bitmap; bit i set = buffer id i allocated.
REQ-016 SHALL use FSM states IDLE, ACK; IDLE -> ACK when wbs_cycle & wbs_strobe sampled high; ACK -> IDLE unconditionally.
REQ-017 SHALL assert wbs_ack only in ACK, exactly one cycle per accepted request; latency = request sampled at edge k, ack high during cycle k..k+1.
REQ-018 SHALL apply side effects, status updates, and the wbs_readdata load on the IDLE -> ACK edge.
REQ-019 SHALL treat a request still present in IDLE after ACK as a new transfer (master drops strobe after ack).
REQ-020 SHALL map offset 0 (addr[3:2]=0) read as ALLOC: return lowest-index free id, zero-extended, and set its bit.
REQ-021 SHALL, on ALLOC with no free buffer, return all-ones, leave the bitmap unchanged, and set STATUS[0] (alloc_empty).
REQ-022 SHALL map offset 0 write as RELEASE of id = wbs_writedata; clear that bit when id < NUM_BUFS and the bit is set.
REQ-023 SHALL, on RELEASE of id >= NUM_BUFS, change nothing in the bitmap and set STATUS[2] (bad_id).
REQ-024 SHALL, on RELEASE of an already-free id, change nothing in the bitmap and set STATUS[1] (double_release).
REQ-025 SHALL map offset 1 read to free_count; offset 1 write SHALL be acked and ignored.
REQ-026 SHALL map offset 2 read to STATUS {zeros, bad_id, double_release, alloc_empty}; offset 2 write SHALL clear bits written as 1 (W1C).
REQ-027 SHALL let a W1C clear and a same-transfer flag set never coincide (single port); flags stay set until cleared or reset.
REQ-028 SHALL map offset 3 reads to 0 and ignore offset 3 writes; all offsets acked.
REQ-029 SHALL update free_count and all_busy registered, consistent with the bitmap in the cycle wbs_ack is high.
REQ-030 SHALL hold wbs_readdata from the last read until the next read; writes leave it unchanged.

Reset
REQ-031 SHALL, on reset_n low, asynchronously force state=IDLE, in_use=0, STATUS=0, wbs_ack=0, wbs_readdata=0, free_count=NUM_BUFS, all_busy=0.
REQ-032 SHALL abort any in-flight transfer on reset (ack dropped immediately, side effect of the next edge not applied).
REQ-033 SHALL accept the first request on the first rising edge with reset_n high.

Verification
REQ-034 Reset then 8 ALLOC reads -> readdata 0,1,..,7 with one ack each, free_count 8->0, all_busy=1 after the 8th.
REQ-035 9th ALLOC with pool empty -> readdata 0xFFFFFFFF, STATUS=0x1, free_count stays 0.
REQ-036 Release id 5, then ALLOC -> free_count 1 after release, ALLOC returns 5, free_count 0.
REQ-037 Release id 3 twice, then id 9 -> 2nd release sets STATUS[1], id 9 sets STATUS[2], free_count incremented once; write 0x6 to offset 2 -> STATUS=0x1 or 0x0 per prior flags.
REQ-038 Strobe held continuously across 3 reads -> ack high every other cycle, three distinct ids returned.
REQ-039 reset_n asserted while in ACK after an ALLOC -> ack low at once, free_count=NUM_BUFS, next ALLOC returns 0.
